// File: rtl/x_300_mod_461_loader.sv
// Loads ten 32-bit words into a 300-bit operand, then produces operand mod 461
// through a valid/ready result handshake.
//
// state | meaning
// LOAD  | accepting words, counter selects the destination slice
// CALC  | one cycle: residue of the full operand is registered
// HOLD  | result presented until out_ready
module x_300_mod_461_loader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [8:0]  out_res,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [3:0]   cnt_q;
  logic [299:0] op_q;
  logic [8:0]   res_q;
  logic         xfer;
  logic [31:0]  acc;
  logic [8:0]   residue;

  // 2^(9i) mod 461, the weight of 9-bit digit i
  function automatic logic [31:0] pow_w(input int i);
    logic [31:0] w;
    w = 32'd1;
    for (int k = 0; k < i; k++) begin
      w = (w * 32'd51) % 32'd461;
    end
    return w;
  endfunction

  function automatic logic [31:0] fold(input logic [31:0] v);
    return 32'(v[8:0]) + 32'(v[17:9]) * pow_w(1) + 32'(v[26:18]) * pow_w(2)
           + 32'(v[31:27]) * pow_w(3);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt_q == 4'd9) state_d = CALC;
      end
      CALC: state_d = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  assign xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      op_q  <= '0;
    end else if (xfer) begin
      cnt_q <= (cnt_q == 4'd9) ? 4'd0 : cnt_q + 4'd1;
      // Last word only has 12 bits that fit the 300-bit operand
      if (cnt_q == 4'd9) begin
        op_q[299:288] <= in_data[11:0];
      end else begin
        for (int k = 0; k < 9; k++) begin
          if (cnt_q == 4'(k)) op_q[32*k +: 32] <= in_data;
        end
      end
    end
  end

  // Digit fold to a 23-bit sum, then four narrow folds bring it to <= 613
  always_comb begin
    acc = 32'd0;
    for (int i = 0; i < 33; i++) begin
      acc = acc + 32'(op_q[9*i +: 9]) * pow_w(i);
    end
    acc = acc + 32'(op_q[299:297]) * pow_w(33);
    for (int j = 0; j < 4; j++) begin
      acc = fold(acc);
    end
    residue = (acc >= 32'd461) ? 9'(acc - 32'd461) : acc[8:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= 9'd0;
    end else if (state_q == CALC) begin
      res_q <= residue;
    end
  end

  assign out_res = res_q;

endmodule

// File: tb/tb_x_300_mod_461_loader.sv
// Randomized and directed bench for x_300_mod_461_loader; expected residues come
// from a word-wise Horner reduction of the loaded operand.
module tb_x_300_mod_461_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  out_res;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int results_seen = 0;

  always #5 clk = ~clk;

  x_300_mod_461_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_res   (out_res),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // X = sum w[k]*2^(32k), word 9 truncated to 12 bits; reduced most-significant word first
  function automatic int ref_mod(input logic [31:0] w [10]);
    longint r;
    longint v;
    r = 0;
    for (int k = 9; k >= 0; k--) begin
      v = (k == 9) ? longint'(w[k] & 32'h0000_0FFF) : longint'(w[k]);
      r = ((r << 32) + v) % 461;
    end
    return int'(r);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input bit keep);
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      repeat ($urandom_range(1, 3)) step();
    end
    in_data  = w;
    in_valid = 1'b1;
    if (gaps) out_ready = 1'($urandom_range(0, 1));
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready: in_ready=%b expected 1", in_ready);
    end
    step();
    if (!keep) begin
      in_valid = 1'b0;
      in_data  = $urandom;
    end
  endtask

  task automatic send_operand(input logic [31:0] w [10], input bit gaps, input bit keep_last);
    for (int k = 0; k < 10; k++) send_word(w[k], gaps, keep_last && (k == 9));
  endtask

  // Entered one step after the edge that accepted word 9
  task automatic check_result(input int expv, input string name, input int stall);
    out_ready = 1'($urandom_range(0, 1));
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s calc_phase: out_valid=%b in_ready=%b expected 0 0", name, out_valid, in_ready);
    end
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s latency: out_valid=%b expected 1", name, out_valid);
    end
    checks++;
    if (out_res !== 9'(expv)) begin
      failures++;
      $display("FAIL %s residue: out_res=%0d expected %0d", name, out_res, expv);
    end
    results_seen++;
    for (int s = 0; s < stall; s++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res !== 9'(expv)) begin
        failures++;
        $display("FAIL %s hold_stable: out_valid=%b in_ready=%b out_res=%0d expected 1 0 %0d",
                 name, out_valid, in_ready, out_res, expv);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_res !== 9'(expv)) begin
      failures++;
      $display("FAIL %s after_handshake: out_valid=%b in_ready=%b out_res=%0d expected 0 1 %0d",
               name, out_valid, in_ready, out_res, expv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || out_res !== 9'd0) begin
      failures++;
      $display("FAIL reset_outputs: out_valid=%b out_res=%0d expected 0 0", out_valid, out_res);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [31:0] w [10];
    w = '{default: 32'd0};
    send_operand(w, 1'b0, 1'b0);
    check_result(0, "all_zero", 0);
    w[0] = 32'd461;
    send_operand(w, 1'b0, 1'b0);
    check_result(0, "x_461", 1);
    w[0] = 32'd460;
    send_operand(w, 1'b0, 1'b0);
    check_result(460, "x_460", 0);
    w[0] = 32'd462;
    send_operand(w, 1'b0, 1'b0);
    check_result(1, "x_462", 2);
    w[0] = 32'h200;
    send_operand(w, 1'b0, 1'b0);
    check_result(51, "x_512", 0);
    w[0] = 32'd0;
    w[9] = 32'hFFFF_FFFF;
    send_operand(w, 1'b0, 1'b0);
    check_result(ref_mod(w), "top_word_ones", 0);
    w[9] = 32'h0000_0FFF;
    send_operand(w, 1'b0, 1'b0);
    check_result(ref_mod(w), "top_word_fff", 0);
  endtask

  task automatic test_stall_in_valid();
    logic [31:0] w [10];
    w = '{default: 32'hFFFF_FFFF};
    send_operand(w, 1'b0, 1'b1);
    check_result(ref_mod(w), "all_ones_stall", 5);
    w = '{default: 32'd0};
    w[1] = 32'd7;
    send_operand(w, 1'b0, 1'b0);
    check_result(ref_mod(w), "after_stall", 0);
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w [10];
    for (int k = 0; k < 10; k++) w[k] = $urandom;
    for (int k = 0; k < 6; k++) send_word(w[k], 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_res !== 9'd0) begin
      failures++;
      $display("FAIL reset_mid_load: out_valid=%b out_res=%0d expected 0 0", out_valid, out_res);
    end
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset_release_idle: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
    end
    w = '{default: 32'd0};
    w[0] = 32'd1;
    send_operand(w, 1'b0, 1'b0);
    check_result(1, "x_one_after_reset", 0);
  endtask

  task automatic test_reset_in_hold();
    logic [31:0] w [10];
    for (int k = 0; k < 10; k++) w[k] = $urandom;
    send_operand(w, 1'b0, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_res !== 9'(ref_mod(w))) begin
      failures++;
      $display("FAIL hold_before_reset: out_valid=%b out_res=%0d expected 1 %0d",
               out_valid, out_res, ref_mod(w));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_res !== 9'd0) begin
      failures++;
      $display("FAIL reset_in_hold: out_valid=%b out_res=%0d expected 0 0", out_valid, out_res);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hold_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    logic [31:0] w [10];
    int mode;
    int start_seen;
    start_seen = results_seen;
    for (int n = 0; n < 1000; n++) begin
      mode = int'($urandom_range(0, 7));
      for (int k = 0; k < 10; k++) begin
        if (mode == 0)      w[k] = 32'd0;
        else if (mode == 1) w[k] = 32'hFFFF_FFFF;
        else                w[k] = $urandom;
      end
      send_operand(w, 1'b1, 1'($urandom_range(0, 1)));
      check_result(ref_mod(w), "random", int'($urandom_range(0, 3)));
    end
    checks++;
    if (results_seen - start_seen != 1000) begin
      failures++;
      $display("FAIL random_count: results=%0d expected 1000", results_seen - start_seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_in_valid();
    test_reset_mid_load();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x_300_mod_461_loader.md
X_300_MOD_461_LOADER -- requirements
Module: x_300_mod_461_loader

Interface
REQ-001 Parameters: none; word width is fixed at 32, word count at 10, and modulus at 461.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_data  input  32  operand word; word k carries X bits [32k+32:32k+1], 1-based, k=0..9, least-significant word first.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 out_res  output  9  residue X mod 461, range 0..460.
REQ-008 out_valid  output  1  out_res valid.
REQ-009 out_ready  input  1  downstream accepts out_res this cycle.

Function
REQ-010 A word SHALL transfer on a rising edge where in_valid=1 and in_ready=1; it SHALL NOT transfer otherwise.
REQ-011 Block SHALL hold a 300-bit operand register; word k SHALL be written to bits [min(32k+32,300):32k+1].
REQ-012 Word 9 bits [32:13] (X positions 301..320) SHALL be discarded.
REQ-013 A 4-bit word counter SHALL start at 0, increment per transfer, and return to 0 after word 9.
REQ-014 FSM states: LOAD, CALC, HOLD.
REQ-015 In LOAD, in_ready=1 and out_valid=0; the transfer of word 9 SHALL move the FSM to CALC.
REQ-016 In CALC (exactly one cycle), in_ready=0; the residue of the full 300-bit register SHALL be registered into out_res; the FSM SHALL then move to HOLD.
REQ-017 Residue SHALL equal the integer value of the operand register mod 461. Implementation uses 9-bit digit folding with weights 2^(9i) mod 461 (2^9 mod 461 = 51), then a final conditional subtract of 461.
REQ-018 In HOLD, out_valid=1 and in_ready=0; out_res and the operand register SHALL stay stable.
REQ-019 In HOLD, out_ready=1 SHALL complete the handshake; the FSM SHALL return to LOAD with counter 0 and out_valid deasserting next cycle.
REQ-020 Latency: word 9 accepted at edge N; out_valid=1 after edge N+1; earliest next word accepted at edge N+3.
REQ-021 in_valid in CALC/HOLD SHALL be ignored with no state change; no word is lost, because in_ready=0.
REQ-022 out_ready in LOAD/CALC SHALL have no effect.
REQ-023 Gaps (in_valid=0) between words SHALL NOT disturb counter or operand bits already loaded.
REQ-024 out_res SHALL keep its last value after the handshake until the next CALC overwrites it.

Reset
REQ-025 rst_n=0 SHALL immediately force: FSM=LOAD, counter=0, operand register=0, out_res=0, out_valid=0, in_ready=1 (after release).
REQ-026 Reset asserted mid-load or in HOLD SHALL discard the partial operand or pending result; no out_valid pulse SHALL follow release.
REQ-027 First transfer is allowed on the first rising edge after rst_n deasserts.

Verification
REQ-028 Ten words all 0 -> out_res=0, out_valid after 1 CALC cycle.
REQ-029 Word0=461, others 0 -> out_res=0; word0=460 -> 460; word0=462 -> 1.
REQ-030 Word0=0x200 (X=512), others 0 -> out_res=51; word9=0xFFFFFFFF, others 0 -> only bits 289..300 set (X=4095·2^288), out_res matches golden model, and the ignored bits have no effect.
REQ-031 All words 0xFFFFFFFF (X=2^300-1) -> out_res equals golden (2^300-1) mod 461; in_valid held high throughout CALC/HOLD with out_ready=0 for 5 cycles -> out_res stable, in_ready=0, counter unchanged.
REQ-032 rst_n pulsed low after word 5 -> out_valid stays 0; a fresh 10-word load of X=1 -> out_res=1.
REQ-033 Random: 1000 operands, random in_valid gaps, random out_ready stalls -> every out_res matches the reference model, one result per 10 words, none dropped or duplicated.
